// File: rtl/obstacle_scheduler.sv
// Obstacle pool scheduler for Dino Run: spawns slots at the right edge, scrolls them
// left once per game tick, retires them at the left edge and ramps speed with passes.
module obstacle_scheduler #(
    parameter int NSLOTS         = 4,
    parameter int HACTIVE        = 1280,
    parameter int TICK_DIV       = 2000000,
    parameter int MIN_GAP        = 200,
    parameter int SPEED_INIT     = 1,
    parameter int SPEED_MAX      = 8,
    parameter int PASS_PER_LEVEL = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  restart,
    output logic [NSLOTS-1:0]     slot_active,
    output logic [11*NSLOTS-1:0]  slot_x,
    output logic [2*NSLOTS-1:0]   slot_kind,
    output logic [3:0]            speed,
    output logic                  tick
);

    localparam int TCW = $clog2(TICK_DIV + 1);
    localparam int PCW = $clog2(PASS_PER_LEVEL + NSLOTS + 1);

    logic [TCW-1:0] tick_cnt;
    logic [PCW-1:0] pass_cnt;
    logic [9:0]     gap;
    logic [7:0]     lfsr;

    logic [NSLOTS-1:0]    act_n;
    logic [11*NSLOTS-1:0] x_n;
    logic [2*NSLOTS-1:0]  kind_n;
    logic [3:0]           speed_n;
    logic [PCW-1:0]       pass_n;
    logic [PCW-1:0]       retire_cnt;
    logic [PCW-1:0]       pass_sum;
    logic [9:0]           gap_n;
    logic [7:0]           lfsr_n;
    logic                 free_found;
    int                   spawn_idx;

    logic terminal;
    assign terminal = (tick_cnt == TCW'(TICK_DIV - 1));

    // Next state for one game tick; every decision uses the pre-tick slot state.
    always_comb begin
        act_n      = slot_active;
        x_n        = slot_x;
        kind_n     = slot_kind;
        speed_n    = speed;
        pass_n     = pass_cnt;
        gap_n      = gap;
        retire_cnt = '0;
        free_found = 1'b0;
        spawn_idx  = 0;
        lfsr_n     = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

        for (int i = 0; i < NSLOTS; i++) begin
            if (!slot_active[i] && !free_found) begin
                free_found = 1'b1;
                spawn_idx  = i;
            end
        end

        for (int i = 0; i < NSLOTS; i++) begin
            if (slot_active[i]) begin
                if (slot_x[11*i +: 11] > {7'b0, speed}) begin
                    x_n[11*i +: 11] = slot_x[11*i +: 11] - {7'b0, speed};
                end else begin
                    act_n[i]   = 1'b0;
                    retire_cnt = retire_cnt + PCW'(1);
                end
            end
        end

        pass_sum = pass_cnt + retire_cnt;
        if (pass_sum >= PCW'(PASS_PER_LEVEL)) begin
            pass_n  = '0;
            speed_n = (speed < 4'(SPEED_MAX)) ? speed + 4'd1 : speed;
        end else begin
            pass_n  = pass_sum;
        end

        // A spawned slot was free this tick, so the motion loop above never touched it.
        if (gap == 10'd0) begin
            if (free_found) begin
                act_n[spawn_idx]          = 1'b1;
                x_n[11*spawn_idx +: 11]   = 11'(HACTIVE);
                kind_n[2*spawn_idx +: 2]  = lfsr[1:0];
                gap_n = 10'(MIN_GAP) + {2'b0, lfsr[7:2], 2'b0};
            end
        end else begin
            gap_n = (gap > {6'b0, speed}) ? gap - {6'b0, speed} : 10'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_active <= '0;
            slot_x      <= '0;
            slot_kind   <= '0;
            speed       <= 4'(SPEED_INIT);
            tick        <= 1'b0;
            tick_cnt    <= '0;
            pass_cnt    <= '0;
            gap         <= '0;
            lfsr        <= 8'hA5;
        end else if (restart) begin
            slot_active <= '0;
            slot_x      <= '0;
            slot_kind   <= '0;
            speed       <= 4'(SPEED_INIT);
            tick        <= 1'b0;
            tick_cnt    <= '0;
            pass_cnt    <= '0;
            gap         <= '0;
        end else if (run) begin
            if (terminal) begin
                tick_cnt    <= '0;
                tick        <= 1'b1;
                slot_active <= act_n;
                slot_x      <= x_n;
                slot_kind   <= kind_n;
                speed       <= speed_n;
                pass_cnt    <= pass_n;
                gap         <= gap_n;
                lfsr        <= lfsr_n;
            end else begin
                tick_cnt    <= tick_cnt + TCW'(1);
                tick        <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Bench for obstacle_scheduler: a pool-level model checked every cycle, plus directed
// literal checks for first spawn, gap, speed saturation, restart, run freeze and reset.
module tb_obstacle_scheduler;

    localparam int TD = 4;
    localparam int NS = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        restart = 1'b0;
    logic [3:0]  slot_active;
    logic [43:0] slot_x;
    logic [7:0]  slot_kind;
    logic [3:0]  speed;
    logic        tick;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    obstacle_scheduler #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .run(run), .restart(restart),
        .slot_active(slot_active), .slot_x(slot_x), .slot_kind(slot_kind),
        .speed(speed), .tick(tick)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model of the pool ----------------
    bit       m_act[NS];
    int       m_x[NS];
    int       m_kind[NS];
    int       m_speed, m_pass, m_gap, m_tcnt;
    bit       m_tick;
    bit [7:0] m_lfsr;

    task automatic model_clear();
        for (int i = 0; i < NS; i++) begin m_act[i] = 0; m_x[i] = 0; m_kind[i] = 0; end
        m_speed = 1; m_pass = 0; m_gap = 0; m_tcnt = 0; m_tick = 0;
    endtask

    task automatic model_game_tick();
        int free_i = -1;
        int p = 0;
        int s0 = m_speed;
        for (int i = 0; i < NS; i++) if (!m_act[i] && free_i < 0) free_i = i;
        for (int i = 0; i < NS; i++) begin
            if (m_act[i]) begin
                if (m_x[i] > s0) m_x[i] = m_x[i] - s0;
                else begin m_act[i] = 0; p++; end
            end
        end
        if (m_pass + p >= 12) begin
            m_pass = 0;
            if (m_speed < 8) m_speed++;
        end else m_pass = m_pass + p;
        if (m_gap == 0) begin
            if (free_i >= 0) begin
                m_act[free_i] = 1; m_x[free_i] = 1280; m_kind[free_i] = m_lfsr % 4;
                m_gap = 200 + 4 * (m_lfsr / 4);
            end
        end else m_gap = (m_gap > s0) ? m_gap - s0 : 0;
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_clear();
            m_lfsr = 8'hA5;
        end else if (restart) begin
            model_clear();
        end else if (run) begin
            if (m_tcnt == TD - 1) begin
                m_tcnt = 0; model_game_tick(); m_tick = 1;
            end else begin
                m_tcnt++; m_tick = 0;
            end
        end else m_tick = 0;
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            if (failures <= 40) $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0]  ea;
            logic [43:0] ex;
            logic [7:0]  ek;
            for (int i = 0; i < NS; i++) begin
                ea[i] = m_act[i];
                ex[11*i +: 11] = 11'(m_x[i]);
                ek[2*i +: 2] = 2'(m_kind[i]);
            end
            chk("model_active", 64'(slot_active), 64'(ea));
            chk("model_x", 64'(slot_x), 64'(ex));
            chk("model_kind", 64'(slot_kind), 64'(ek));
            chk("model_speed", 64'(speed), 64'(m_speed));
            chk("model_tick", 64'(tick), 64'(m_tick));
        end
    end

    // Waits up to bound cycles for a tick pulse; n = cycles waited.
    task automatic wait_tick(input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < bound);
        if (tick !== 1'b1) chk("tick_timeout", 64'(tick), 64'd1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_active"}, 64'(slot_active), 64'd0);
        chk({tag, "_x"}, 64'(slot_x), 64'd0);
        chk({tag, "_kind"}, 64'(slot_kind), 64'd0);
        chk({tag, "_speed"}, 64'(speed), 64'd1);
        chk({tag, "_tick"}, 64'(tick), 64'd0);
    endtask

    initial begin
        int n;
        int frozen_ticks;
        #1 reset = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_values("reset");
        reset = 1'b0;
        run = 1'b1;

        // First spawn: tick after TICK_DIV cycles, slot 0 at the right edge, kind 1
        wait_tick(20, n);
        chk("first_tick_latency", 64'(n), 64'd4);
        chk("first_active", 64'(slot_active), 64'h1);
        chk("first_x0", 64'(slot_x[10:0]), 64'd1280);
        chk("first_kind0", 64'(slot_kind[1:0]), 64'd1);
        chk("first_speed", 64'(speed), 64'd1);

        wait_tick(20, n);
        chk("tick2_x0", 64'(slot_x[10:0]), 64'd1279);

        // gap 364 runs out on tick 365; slot 1 spawns on tick 366
        for (int t = 3; t <= 365; t++) wait_tick(20, n);
        chk("tick365_active", 64'(slot_active), 64'h1);
        wait_tick(20, n);
        chk("tick366_active", 64'(slot_active), 64'h3);
        chk("tick366_x0", 64'(slot_x[10:0]), 64'd915);
        chk("tick366_x1", 64'(slot_x[21:11]), 64'd1280);

        // Speed ramp to saturation
        n = 0;
        for (int t = 0; t < 16000 && speed != 4'd8; t++) wait_tick(20, n);
        chk("speed_reaches_max", 64'(speed), 64'd8);
        for (int t = 0; t < 150; t++) wait_tick(20, n);
        chk("speed_saturated", 64'(speed), 64'd8);

        // restart coincident with the terminal count
        wait_tick(20, n);
        repeat (3) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk_reset_values("restart");
        wait_tick(20, n);
        chk("restart_tick_latency", 64'(n), 64'd4);
        chk("restart_spawn_active", 64'(slot_active), 64'h1);
        chk("restart_spawn_x0", 64'(slot_x[10:0]), 64'd1280);

        // run dropped on the terminal-count edge suppresses the tick and freezes state
        for (int t = 0; t < 20; t++) wait_tick(20, n);
        repeat (3) @(negedge clk);
        run = 1'b0;
        frozen_ticks = 0;
        repeat (40) begin
            @(negedge clk);
            if (tick === 1'b1) frozen_ticks++;
        end
        chk("frozen_no_ticks", 64'(frozen_ticks), 64'd0);
        run = 1'b1;
        wait_tick(20, n);
        chk("resume_tick_latency", 64'(n), 64'd1);

        // Asynchronous reset in the middle of a tick period
        wait_tick(20, n);
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk_reset_values("async_reset");
        reset = 1'b0;
        wait_tick(20, n);
        chk("post_reset_tick_latency", 64'(n), 64'd4);
        chk("post_reset_kind0", 64'(slot_kind[1:0]), 64'd1);
        @(negedge clk);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
